// File: rtl/sd_pkg.sv
// Shared constants and helpers for the sigma-delta CIC decimator family.
package sd_pkg;

  localparam int unsigned CIC_ORDER = 3;

  typedef logic signed [63:0] wide_t;

  // Internal CIC width: one bit of headroom beyond the R^3 gain plus sign.
  function automatic int unsigned cic_width(input int unsigned rlog2);
    return CIC_ORDER * rlog2 + 2;
  endfunction

  function automatic int unsigned cic_shift(input int unsigned rlog2, input int unsigned dw);
    return CIC_ORDER * rlog2 - (dw - 1);
  endfunction

  function automatic wide_t sat_dw(input wide_t v, input int unsigned dw);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (dw - 1));
    if (v > hi) begin
      return hi;
    end
    if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/sd_cic3_dec.sv
// Single-channel third-order CIC decimator: integrators at the bit rate,
// combs at the decimated rate, scaled and saturated to DW bits.
module sd_cic3_dec
  import sd_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned RLOG2 = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          sd_bit,
  input  logic          tick_d,
  output logic [DW-1:0] sample
);

  localparam int unsigned CW = cic_width(RLOG2);
  localparam int unsigned SH = cic_shift(RLOG2, DW);

  logic signed [CW-1:0] x;
  logic signed [CW-1:0] i1_q, i2_q, i3_q;
  logic signed [CW-1:0] i1_d, i2_d, i3_d;
  logic signed [CW-1:0] d1_q, d2_q, d3_q;
  logic signed [CW-1:0] c1, c2, c3;
  logic signed [CW-1:0] shifted;

  // 1 -> +1 (0..01), 0 -> -1 (all ones)
  assign x = {{(CW - 1){~sd_bit}}, 1'b1};

  always_comb begin
    i1_d    = i1_q + x;
    i2_d    = i2_q + i1_d;
    i3_d    = i3_q + i2_d;
    c1      = i3_q - d1_q;
    c2      = c1 - d2_q;
    c3      = c2 - d3_q;
    shifted = c3 >>> SH;
    sample  = DW'(sat_dw(wide_t'(shifted), DW));
  end

  // Integrators wrap modulo 2^CW; the comb differences recover the exact result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i1_q <= '0;
      i2_q <= '0;
      i3_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
    end else begin
      if (cen) begin
        i1_q <= i1_d;
        i2_q <= i2_d;
        i3_q <= i3_d;
      end
      if (tick_d) begin
        d1_q <= i3_q;
        d2_q <= c1;
        d3_q <= c2;
      end
    end
  end

endmodule

// File: rtl/sd2_adc_dec.sv
// Stereo sigma-delta bitstream decoder: two CIC3 decimators sharing one
// decimation counter, with warmup suppression and a valid/ready output stage.
module sd2_adc_dec
  import sd_pkg::*;
#(
  parameter int unsigned DW     = 16,
  parameter int unsigned RLOG2  = 6,
  parameter int unsigned WARMUP = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          left,
  input  logic          right,
  output logic [DW-1:0] pcm_l,
  output logic [DW-1:0] pcm_r,
  output logic          pcm_valid,
  input  logic          pcm_ready,
  output logic          overrun
);

  if (CIC_ORDER * RLOG2 < DW - 1) begin : g_param_check
    $error("sd2_adc_dec: 3*RLOG2 must be >= DW-1");
  end

  localparam int unsigned WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  logic [RLOG2-1:0] cnt_q;
  logic [WW-1:0]    warm_q;
  logic             tick, tick_q;
  logic             warm_done, load;
  logic [DW-1:0]    samp_l, samp_r;
  logic [DW-1:0]    pcm_l_q, pcm_r_q;
  logic             valid_q, overrun_q;

  assign tick      = cen & (cnt_q == '1);
  assign warm_done = (warm_q == WW'(WARMUP));
  assign load      = tick_q & warm_done;

  sd_cic3_dec #(
    .DW    (DW),
    .RLOG2 (RLOG2)
  ) u_cic_l (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (cen),
    .sd_bit (left),
    .tick_d (tick_q),
    .sample (samp_l)
  );

  sd_cic3_dec #(
    .DW    (DW),
    .RLOG2 (RLOG2)
  ) u_cic_r (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (cen),
    .sd_bit (right),
    .tick_d (tick_q),
    .sample (samp_r)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      warm_q    <= '0;
      tick_q    <= 1'b0;
      pcm_l_q   <= '0;
      pcm_r_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (cen) begin
        cnt_q <= cnt_q + 1'b1;
      end
      tick_q <= tick;
      if (tick_q && !warm_done) begin
        warm_q <= warm_q + 1'b1;
      end
      // A new load wins over acceptance; overwriting an unaccepted sample is sticky.
      if (load) begin
        pcm_l_q <= samp_l;
        pcm_r_q <= samp_r;
        valid_q <= 1'b1;
        if (valid_q && !pcm_ready) begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && pcm_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign pcm_l     = pcm_l_q;
  assign pcm_r     = pcm_r_q;
  assign pcm_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sd2_adc_dec.sv
// Scoreboard bench for sd2_adc_dec: reference output is the bitstream convolved
// with the CIC3 impulse response, scaled and clamped.
module tb_sd2_adc_dec;

  localparam int DW     = 16;
  localparam int RLOG2  = 6;
  localparam int WARMUP = 3;
  localparam int R      = 1 << RLOG2;
  localparam int SH     = 3 * RLOG2 - (DW - 1);
  localparam int HLEN   = 3 * (R - 1) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen = 1'b0;
  logic          left = 1'b0;
  logic          right = 1'b0;
  logic          pcm_ready = 1'b1;
  logic [DW-1:0] pcm_l, pcm_r;
  logic          pcm_valid, overrun;

  sd2_adc_dec #(
    .DW     (DW),
    .RLOG2  (RLOG2),
    .WARMUP (WARMUP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .left      (left),
    .right     (right),
    .pcm_l     (pcm_l),
    .pcm_r     (pcm_r),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic          ovr;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            h[HLEN];
  int            hist_l[$];
  int            hist_r[$];
  int            ncen, nticks, gk;
  logic          exp_ovr;
  int            cyc = 0;
  int            prev_rise = -1;
  int            last_rise = -1;
  int            n_rise = 0;
  logic          last_valid = 1'b0;
  logic [DW-1:0] acc_l, acc_r;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Convolution with the CIC3 impulse response; history before reset is zero.
  function automatic logic [DW-1:0] ref_sample(input int hist[$]);
    longint y;
    int     n;
    y = 0;
    n = hist.size();
    for (int m = 0; m < HLEN; m++) begin
      if (n - 1 - m >= 0) y += longint'(h[m]) * longint'(hist[n-1-m]);
    end
    y = y >>> SH;
    if (y > (2 ** (DW - 1)) - 1) y = (2 ** (DW - 1)) - 1;
    if (y < -(2 ** (DW - 1))) y = -(2 ** (DW - 1));
    return y[DW-1:0];
  endfunction

  task automatic reset_model();
    hist_l.delete();
    hist_r.delete();
    sb.delete();
    ncen    = 0;
    nticks  = 0;
    exp_ovr = 1'b0;
  endtask

  task automatic step(input logic c, input logic l, input logic r);
    cen   = c;
    left  = l;
    right = r;
    @(posedge clk);
    gk++;
    if (c && rst_n) begin
      hist_l.push_back(l ? 1 : -1);
      hist_r.push_back(r ? 1 : -1);
      if (hist_l.size() > HLEN) void'(hist_l.pop_front());
      if (hist_r.size() > HLEN) void'(hist_r.pop_front());
      ncen++;
      if (ncen % R == 0) begin
        nticks++;
        if (nticks > WARMUP) begin
          exp_t e;
          e.l = ref_sample(hist_l);
          e.r = ref_sample(hist_r);
          // An unaccepted sample still queued here gets overwritten in the DUT.
          if (sb.size() > 0) begin
            void'(sb.pop_back());
            exp_ovr = 1'b1;
          end
          e.ovr = exp_ovr;
          sb.push_back(e);
        end
      end
    end
    #1;
  endtask

  // pat: 0 zeros, 1 ones, 2 1010/1100, 3 1110/1000, else random.
  // cmode: 0 every clock, 1 every 4th clock, else random.
  task automatic run(input int n, input int pat, input int cmode);
    for (int k = 0; k < n; k++) begin
      logic c, l, r;
      case (cmode)
        0:       c = 1'b1;
        1:       c = (gk % 4 == 0);
        default: c = 1'($urandom_range(0, 1));
      endcase
      case (pat)
        0:       begin l = 1'b0;            r = 1'b0;           end
        1:       begin l = 1'b1;            r = 1'b1;           end
        2:       begin l = (gk % 2 == 0);   r = (gk % 4 < 2);   end
        3:       begin l = (gk % 4 != 3);   r = (gk % 4 == 0);  end
        default: begin l = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1)); end
      endcase
      step(c, l, r);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (pcm_valid === 1'b1 && last_valid !== 1'b1) begin
      prev_rise = last_rise;
      last_rise = cyc;
      n_rise++;
    end
    last_valid = pcm_valid;
    if (pcm_valid === 1'b1 && pcm_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_sample: got l=%0h r=%0h, expected no sample", pcm_l, pcm_r);
      end else begin
        e = sb.pop_front();
        check("pcm_l", 32'(pcm_l), 32'(e.l));
        check("pcm_r", 32'(pcm_r), 32'(e.r));
        check("overrun_at_accept", 32'(overrun), 32'(e.ovr));
        acc_l = pcm_l;
        acc_r = pcm_r;
      end
    end
  end

  initial begin
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++) h[a+b+c]++;
    gk = 0;
    reset_model();

    rst_n     = 1'b0;
    pcm_ready = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("rst_pcm_l", 32'(pcm_l), 0);
    check("rst_pcm_r", 32'(pcm_r), 0);
    check("rst_valid", 32'(pcm_valid), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;

    // All ones: first valid two clocks after the 256th cen cycle.
    for (int k = 0; k < 6 * R; k++) begin
      step(1'b1, 1'b1, 1'b1);
      if (k == 4 * R - 1) check("valid_before_first", 32'(pcm_valid), 0);
      if (k == 4 * R) check("first_valid", 32'(pcm_valid), 1);
    end
    check("ones_l", 32'(acc_l), 32'h7fff);
    check("ones_r", 32'(acc_r), 32'h7fff);

    run(5 * R, 0, 0);
    check("zeros_l", 32'(acc_l), 32'h8000);
    check("zeros_r", 32'(acc_r), 32'h8000);

    run(5 * R, 2, 0);
    check("alt_l", 32'(acc_l), 32'h0000);
    check("alt_r", 32'(acc_r), 32'h0000);

    run(5 * R, 3, 0);
    check("duty75_l", 32'(acc_l), 32'h4000);
    check("duty25_r", 32'(acc_r), 32'hc000);

    // Overrun: hold ready low across two loads, then accept once.
    for (int k = 0; k < R && (ncen % R) != 10; k++) run(1, 3, 0);
    pcm_ready = 1'b0;
    run(2 * R, 3, 0);
    check("valid_held", 32'(pcm_valid), 1);
    check("overrun_set", 32'(overrun), 1);
    pcm_ready = 1'b1;
    run(1, 3, 0);
    pcm_ready = 1'b0;
    check("valid_cleared", 32'(pcm_valid), 0);
    check("overrun_sticky", 32'(overrun), 1);
    run(1, 3, 0);
    check("data_hold", 32'(pcm_l), 32'h4000);
    pcm_ready = 1'b1;

    // cen every 4th clock, then a reset pulse mid-frame.
    run(6 * 4 * R, 4, 1);
    for (int k = 0; k < 4 * R && (ncen % R) != 30; k++) run(1, 4, 1);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    reset_model();
    check("midrst_pcm_l", 32'(pcm_l), 0);
    check("midrst_pcm_r", 32'(pcm_r), 0);
    check("midrst_valid", 32'(pcm_valid), 0);
    check("midrst_overrun", 32'(overrun), 0);
    rst_n     = 1'b1;
    n_rise    = 0;
    prev_rise = -1;
    last_rise = -1;
    run(7 * 4 * R + 16, 4, 1);
    check("loads_after_reset", n_rise, 4);
    check("valid_period", last_rise - prev_rise, 4 * R);

    run(3000, 4, 2);
    run(16, 4, 3);
    for (int k = 0; k < 16; k++) step(1'b0, 1'b0, 1'b0);
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
